// File: rtl/hisse_alim_yurutucu.sv
// hisse_alim_yurutucu: divides the balance by the unit price, issues a buy order and debits the balance on handshake; optional KOMISYON_EN
module hisse_alim_yurutucu #(
    parameter int NO_W     = 10,
    parameter int FIYAT_W  = 32,
    parameter int BAKIYE_W = 64,
    parameter int KOMISYON = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bakiye_yukle,
    input  logic [BAKIYE_W-1:0] bakiye_giris,
    input  logic                karar_gecerli,
    output logic                karar_hazir,
    input  logic [NO_W-1:0]     karar_no,
    input  logic [FIYAT_W-1:0]  birim_fiyat,
    output logic                emir_gecerli,
    input  logic                emir_hazir,
    output logic [NO_W-1:0]     emir_hisse_no,
    output logic [BAKIYE_W-1:0] emir_adet,
    output logic [BAKIYE_W-1:0] emir_tutar,
    output logic [BAKIYE_W-1:0] bakiye_cikis,
    output logic                mesgul,
    output logic                hata,
    output logic                yetersiz
);
    localparam int SW = $clog2(BAKIYE_W);
    typedef enum logic [1:0] {BOS, BOL, EMIR} durum_t;
    durum_t durum, durum_n;
    logic [BAKIYE_W-1:0] bakiye, bolunen, bolum, kalan;
    logic [BAKIYE_W-1:0] kullanilabilir, bolen, kaydir, kalan_n, bolum_n;
    logic [NO_W-1:0]     no_r;
    logic [FIYAT_W-1:0]  fiyat_r;
    logic [SW-1:0]       sayac;
    logic                hata_r, yetersiz_r, kabul, buyuk, son, kom_yetersiz;
`ifdef KOMISYON_EN
    // the commission is reserved up front; the division only sees what is left
    assign kullanilabilir = bakiye - BAKIYE_W'(KOMISYON);
    assign kom_yetersiz   = bakiye <= BAKIYE_W'(KOMISYON);
`else
    assign kullanilabilir = bakiye;
    assign kom_yetersiz   = 1'b0;
`endif
    assign karar_hazir = (durum == BOS) && !bakiye_yukle;
    assign kabul       = karar_gecerli && karar_hazir;
    // one restoring step: bring in the next dividend bit, subtract when it fits
    assign bolen   = {{(BAKIYE_W-FIYAT_W){1'b0}}, fiyat_r};
    assign kaydir  = {kalan[BAKIYE_W-2:0], bolum[BAKIYE_W-1]};
    assign buyuk   = kaydir >= bolen;
    assign kalan_n = buyuk ? kaydir - bolen : kaydir;
    assign bolum_n = {bolum[BAKIYE_W-2:0], buyuk};
    assign son     = sayac == SW'(BAKIYE_W - 1);
    assign emir_gecerli  = durum == EMIR;
    assign emir_hisse_no = emir_gecerli ? no_r : '0;
    assign emir_adet     = emir_gecerli ? bolum : '0;
    assign emir_tutar    = emir_gecerli ? bolunen - kalan : '0;
    assign bakiye_cikis  = bakiye;
    assign mesgul        = durum != BOS;
    assign hata          = hata_r;
    assign yetersiz      = yetersiz_r;
    // state register
    always_ff @(posedge clk) begin
        if (rst) durum <= BOS;
        else     durum <= durum_n;
    end
    // next state: start dividing on a usable decision, order only when shares are affordable
    always_comb begin
        durum_n = durum;
        case (durum)
            BOS:     durum_n = (kabul && birim_fiyat != '0 && !kom_yetersiz) ? BOL : BOS;
            BOL:     durum_n = son ? (bolum_n != '0 ? EMIR : BOS) : BOL;
            EMIR:    durum_n = emir_hazir ? BOS : EMIR;
            default: durum_n = BOS;
        endcase
    end
    // balance, latched decision, divider datapath and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            bakiye      <= '0;
            bolunen     <= '0;
            bolum       <= '0;
            kalan       <= '0;
            no_r        <= '0;
            fiyat_r     <= '0;
            sayac       <= '0;
            hata_r      <= 1'b0;
            yetersiz_r  <= 1'b0;
        end else begin
            hata_r     <= kabul && birim_fiyat == '0;
            yetersiz_r <= (kabul && birim_fiyat != '0 && kom_yetersiz) ||
                          (durum == BOL && son && bolum_n == '0);
            if (durum == BOS && bakiye_yukle) bakiye <= bakiye_giris;
            if (kabul) begin
                no_r    <= karar_no;
                fiyat_r <= birim_fiyat;
                bolunen <= kullanilabilir;
                bolum   <= kullanilabilir;
                kalan   <= '0;
                sayac   <= '0;
            end
            if (durum == BOL) begin
                bolum <= bolum_n;
                kalan <= kalan_n;
                sayac <= sayac + 1'b1;
            end
            if (durum == EMIR && emir_hazir) bakiye <= kalan;
        end
    end
endmodule
